// File: rtl/bsg_priority_encode.sv
// rtl/bsg_priority_encode.sv - priority encoder over a request vector, direction selectable
module bsg_priority_encode #(
    parameter int width_p       = 32,
    parameter int lo_to_hi_p    = 0,
    parameter int addr_width_lp = $clog2(width_p)
) (
    input  logic [width_p-1:0]       i,
    output logic [addr_width_lp-1:0] addr_o,
    output logic                     v_o
);

    // Scan from the losing end toward the winning end so the last hit wins.
    always_comb begin
        addr_o = '0;
        if (lo_to_hi_p != 0) begin
            for (int k = width_p - 1; k >= 0; k--) begin
                if (i[k]) addr_o = addr_width_lp'(k);
            end
        end else begin
            for (int k = 0; k < width_p; k++) begin
                if (i[k]) addr_o = addr_width_lp'(k);
            end
        end
    end

    assign v_o = |i;

endmodule

// File: rtl/bsg_priority_pending_dequeue.sv
// rtl/bsg_priority_pending_dequeue.sv - sticky pending vector retired one grant per yumi
module bsg_priority_pending_dequeue #(
    parameter int width_p       = 32,
    parameter int lo_to_hi_p    = 0,
    parameter int addr_width_lp = $clog2(width_p),
    parameter int cnt_width_lp  = $clog2(width_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [width_p-1:0]       set_i,
    output logic                     v_o,
    output logic [addr_width_lp-1:0] addr_o,
    input  logic                     yumi_i,
    output logic [width_p-1:0]       pending_o,
    output logic [cnt_width_lp-1:0]  count_o,
    output logic                     coalesce_o,
    output logic                     err_o
);

    logic [width_p-1:0]      pending_q, pending_d;
    logic [cnt_width_lp-1:0] count_q, count_d;
    logic                    coalesce_q, coalesce_d;
    logic                    err_q, err_d;
    logic [width_p-1:0]      clr;
    logic [width_p-1:0]      kept;
    logic                    grant;

    function automatic logic [cnt_width_lp-1:0] popcnt(input logic [width_p-1:0] vec);
        logic [cnt_width_lp-1:0] s;
        s = '0;
        for (int k = 0; k < width_p; k++) s = s + cnt_width_lp'(vec[k]);
        return s;
    endfunction

    bsg_priority_encode #(
        .width_p    (width_p),
        .lo_to_hi_p (lo_to_hi_p)
    ) enc (
        .i      (pending_q),
        .addr_o (addr_o),
        .v_o    (v_o)
    );

    assign grant = yumi_i & v_o;

    always_comb begin
        clr        = grant ? ({{(width_p-1){1'b0}}, 1'b1} << addr_o) : '0;
        kept       = pending_q & ~clr;
        pending_d  = kept | set_i;
        coalesce_d = |(set_i & kept);
        // Bits set on top of surviving entries add nothing; a granted bit re-set counts again.
        count_d    = count_q + popcnt(set_i & ~kept) - cnt_width_lp'(grant);
        err_d      = err_q | (yumi_i & ~v_o);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            pending_q  <= '0;
            count_q    <= '0;
            coalesce_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            count_q    <= count_d;
            coalesce_q <= coalesce_d;
            err_q      <= err_d;
        end
    end

    assign pending_o  = pending_q;
    assign count_o    = count_q;
    assign coalesce_o = coalesce_q;
    assign err_o      = err_q;

    count_matches_pending: assert property (@(posedge clk_i) count_q == popcnt(pending_q));

endmodule

// File: doc/bsg_priority_pending_dequeue.md
Name: bsg_priority_pending_dequeue

Overview:
- Holds a sticky vector of pending one-bit requests, e.g. interrupt or ready flags from many sources.
- Each cycle it presents the index of the highest-priority pending request with a valid flag.
- A yumi handshake retires that request.
- It is the stateful stage directly downstream of the priority encoder: the encoder is instantiated over the pending register, and its address is consumed to clear the granted bit.

Parameters:
- width_p, 32, number of request sources (>=2).
- lo_to_hi_p, 0, priority direction. 0 = highest index wins. 1 = lowest index wins.
- addr_width_lp, $clog2(width_p), derived localparam; width of addr_o.
- cnt_width_lp, $clog2(width_p+1), derived localparam; width of count_o.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- reset_n_i  in  1  synchronous reset, active-low.
- set_i  in  width_p  per-cycle request pulses; bit k marks source k pending.
- v_o  out  1  at least one request pending.
- addr_o  out  addr_width_lp  index of the highest-priority pending request; 0 when v_o=0.
- yumi_i  in  1  consumer accepts addr_o this cycle. Legal only when v_o=1.
- pending_o  out  width_p  current pending vector, for debug and status.
- count_o  out  cnt_width_lp  number of pending requests.
- coalesce_o  out  1  registered pulse: in the previous cycle a set_i bit hit an already-pending, not-cleared entry.
- err_o  out  1  sticky: set when yumi_i=1 while v_o=0; cleared only by reset.

Behaviour:
- State: pending_r[width_p], count_r, coalesce_r, err_r.
- Reset (reset_n_i=0 at a clock edge): all state goes to 0 and set_i/yumi_i are ignored that cycle. After reset: v_o=0, addr_o=0, pending_o=0, count_o=0, coalesce_o=0, err_o=0. Reset mid-operation drops all pending requests without producing any grant.
- v_o = |pending_r. addr_o = priority-encode(pending_r) per lo_to_hi_p.
  - Both are combinational from registered state only; there is no combinational path from set_i or yumi_i to any output.
  - Latency set_i -> v_o/addr_o: 1 cycle.
- Clear mask: clr = (yumi_i & v_o) ? onehot(addr_o) : 0.
- Next state: pending_r <= (pending_r & ~clr) | set_i.
  - Simultaneous set_i[k] and clear of bit k in the same cycle: set wins. The bit stays pending and represents a new request.
- coalesce_r <= |(set_i & pending_r & ~clr).
- count_r tracks popcount(next pending_r) exactly each cycle, kept incrementally as count + popcount(set_i & ~(pending_r & ~clr)) - |clr.
  - Invariant checked by assertion: count_o == popcount(pending_o).
- yumi_i while v_o=0: no state change except err_r <= 1.
- addr_o is not guaranteed stable while v_o=1 without yumi_i.
  - A newly set higher-priority bit preempts the current address on the next cycle.
  - The consumer samples addr_o in the same cycle it asserts yumi_i.
- Throughput: one retire per cycle. With all width_p bits pending and yumi_i held high, the vector drains in exactly width_p cycles if no new sets arrive.
- Full vector (all ones) is legal. Further sets only coalesce; there is no overflow.

Decomposition:
- No shared package: the only constants are the derived widths, computed locally from width_p.
- One sub-module: the existing bsg_priority_encode family, instantiated with width_p/lo_to_hi_p. Its v_o drives v_o.
- Onehot decode, popcount update and flags stay inline in this block.

Test Plan (width_p=32, lo_to_hi_p=0 unless noted):
- Reset, then idle for 5 cycles -> v_o=0, addr_o=0, count_o=0, err_o=0 on every cycle.
- set_i=32'h0000_0005 for one cycle -> next cycle v_o=1, addr_o=2, count_o=2. Then yumi_i=1 -> addr_o=0, count_o=1. Then yumi_i=1 -> v_o=0, count_o=0.
- pending_r=32'h0000_0010 with yumi_i=1 and set_i=32'h0000_0010 in the same cycle -> bit 4 remains pending, count_o=1, coalesce_o=0.
- pending bit 3, then set_i=32'h8000_0008 without yumi_i -> next cycle addr_o=31, coalesce_o=1, count_o=2.
- set_i=32'hFFFF_FFFF once, then yumi_i held high -> addr_o sequence 31,30,...,0 over 32 cycles; v_o falls on cycle 33. Repeat with lo_to_hi_p=1 -> sequence 0..31.
- yumi_i=1 while v_o=0 -> err_o=1 and stays high. Then assert reset_n_i=0 mid-drain with pending=32'hF0 -> all outputs return to 0 the next cycle.
